// File: rtl/pc_sequencer.sv
// Program-counter sequencer: produces fetch addresses with a valid/ready handshake.
// Supports jumps and relative branches, and halts with a sticky fault on a misaligned target.
module pc_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] entry_point,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_offset,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             ready_out,
  output logic [WIDTH-1:0] pc_out,
  output logic             valid_out,
  output logic             fault,
  output logic [WIDTH-1:0] fault_pc,
  output logic [CNTW-1:0]  fetch_count
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e           state_q;
  logic             xfer;
  logic             redirect;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] seq_pc;
  logic             target_misaligned;
  logic             entry_misaligned;
  logic             cnt_sat;

  always_comb begin
    xfer              = valid_out & ready_out;
    redirect          = jmp | br_taken;
    // jmp outranks br_taken; the adder wraps silently at WIDTH bits
    target            = jmp ? jmp_target : (pc_out + br_offset);
    seq_pc            = pc_out + WIDTH'(4);
    target_misaligned = |target[1:0];
    entry_misaligned  = |entry_point[1:0];
    cnt_sat           = &fetch_count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_out      <= '0;
      valid_out   <= 1'b0;
      fault       <= 1'b0;
      fault_pc    <= '0;
      fetch_count <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (entry_misaligned) begin
            state_q   <= StHalt;
            valid_out <= 1'b0;
            fault     <= 1'b1;
            fault_pc  <= entry_point;
          end else begin
            state_q   <= StRun;
            pc_out    <= entry_point;
            valid_out <= 1'b1;
          end
        end
        StRun: begin
          // A transfer is counted even when the same edge halts on a bad redirect
          if (xfer && !cnt_sat) begin
            fetch_count <= fetch_count + CNTW'(1);
          end
          if (redirect) begin
            if (target_misaligned) begin
              state_q   <= StHalt;
              valid_out <= 1'b0;
              fault     <= 1'b1;
              fault_pc  <= target;
            end else begin
              pc_out <= target;
            end
          end else if (xfer) begin
            pc_out <= seq_pc;
          end
        end
        StHalt: begin
          valid_out <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
